// File: rtl/ptpv2_bus_arbiter.sv
// Two-master round-robin arbiter/sequencer for the ptpv2_core register bus.
// Serialises single-word accesses, supports locked sequences with an idle watchdog.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | arbitrate among candidates, track lock idle time
// ISSUE | drive address/data and one read or write strobe
// WAIT  | count read latency, capture ip2bus_data_i at the end
// ACK   | pulse owner ack, advance pointer, resample owner lock
module ptpv2_bus_arbiter #(
    parameter int RD_LAT   = 1,
    parameter int LOCK_MAX = 255
) (
    input  logic        bus2ip_clk,
    input  logic        bus2ip_rst_n,
    input  logic        m0_req_i,
    input  logic        m0_wr_i,
    input  logic        m0_lock_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_ack_o,
    output logic [31:0] m0_rdata_o,
    input  logic        m1_req_i,
    input  logic        m1_wr_i,
    input  logic        m1_lock_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_ack_o,
    output logic [31:0] m1_rdata_o,
    output logic [31:0] bus2ip_addr_o,
    output logic [31:0] bus2ip_data_o,
    output logic        bus2ip_rd_ce_o,
    output logic        bus2ip_wr_ce_o,
    input  logic [31:0] ip2bus_data_i,
    output logic [1:0]  grant_o,
    output logic        lock_to_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

    localparam logic [1:0]  LAT_LOAD = 2'(RD_LAT - 1);
    localparam logic [15:0] WD_LOAD  = 16'(LOCK_MAX);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        prio_q, prio_d;
    logic        lock_held_q, lock_held_d;
    logic [1:0]  lat_cnt_q, lat_cnt_d;
    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic owner_req, owner_lock, lock_active, idle, timeout;
    logic sel_valid, sel_id;

    assign idle        = (state_q == S_IDLE);
    assign owner_req   = owner_q ? m1_req_i  : m0_req_i;
    assign owner_lock  = owner_q ? m1_lock_i : m0_lock_i;
    assign lock_active = lock_held_q && owner_lock;
    assign timeout     = idle && lock_active && !owner_req && (wd_cnt_q == 16'd0);

    // While the lock is live only the owner may win; otherwise ties go to prio_q.
    always_comb begin
        sel_valid = 1'b0;
        sel_id    = prio_q;
        if (idle) begin
            if (lock_active) begin
                sel_valid = owner_req;
                sel_id    = owner_q;
            end else if (m0_req_i && m1_req_i) begin
                sel_valid = 1'b1;
                sel_id    = prio_q;
            end else if (m0_req_i) begin
                sel_valid = 1'b1;
                sel_id    = 1'b0;
            end else if (m1_req_i) begin
                sel_valid = 1'b1;
                sel_id    = 1'b1;
            end
        end
    end

    always_ff @(posedge bus2ip_clk) begin
        if (!bus2ip_rst_n) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            prio_q      <= 1'b0;
            lock_held_q <= 1'b0;
            lat_cnt_q   <= 2'd0;
            wd_cnt_q    <= WD_LOAD;
            rdata0_q    <= 32'h0;
            rdata1_q    <= 32'h0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            prio_q      <= prio_d;
            lock_held_q <= lock_held_d;
            lat_cnt_q   <= lat_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        prio_d      = prio_q;
        lock_held_d = lock_held_q;
        lat_cnt_d   = lat_cnt_q;
        wd_cnt_d    = wd_cnt_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        case (state_q)
            S_IDLE: begin
                if (lock_held_q && !owner_lock) begin
                    lock_held_d = 1'b0;
                end
                if (sel_valid) begin
                    owner_d  = sel_id;
                    wr_d     = sel_id ? m1_wr_i    : m0_wr_i;
                    addr_d   = sel_id ? m1_addr_i  : m0_addr_i;
                    wdata_d  = sel_id ? m1_wdata_i : m0_wdata_i;
                    wd_cnt_d = WD_LOAD;
                    state_d  = S_ISSUE;
                end else if (timeout) begin
                    lock_held_d = 1'b0;
                    wd_cnt_d    = WD_LOAD;
                end else if (lock_active) begin
                    wd_cnt_d = wd_cnt_q - 16'd1;
                end
            end
            S_ISSUE: begin
                if (wr_q) begin
                    state_d = S_ACK;
                end else begin
                    lat_cnt_d = LAT_LOAD;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_cnt_q == 2'd0) begin
                    if (owner_q) rdata1_d = ip2bus_data_i;
                    else         rdata0_d = ip2bus_data_i;
                    state_d = S_ACK;
                end else begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end
            end
            S_ACK: begin
                prio_d      = ~owner_q;
                lock_held_d = owner_lock;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus2ip_rd_ce_o = (state_q == S_ISSUE) && !wr_q;
        bus2ip_wr_ce_o = (state_q == S_ISSUE) && wr_q;
        m0_ack_o       = (state_q == S_ACK) && !owner_q;
        m1_ack_o       = (state_q == S_ACK) && owner_q;
        lock_to_o      = 1'b0;
        grant_o        = 2'b00;
        if (bus2ip_rst_n) begin
            lock_to_o = timeout;
            if (!idle) begin
                grant_o = owner_q ? 2'b10 : 2'b01;
            end else if (sel_valid) begin
                grant_o = sel_id ? 2'b10 : 2'b01;
            end else if (lock_active) begin
                grant_o = owner_q ? 2'b10 : 2'b01;
            end
        end
    end

    assign bus2ip_addr_o = addr_q;
    assign bus2ip_data_o = wdata_q;
    assign m0_rdata_o    = rdata0_q;
    assign m1_rdata_o    = rdata1_q;

endmodule

// File: doc/ptpv2_bus_arbiter.md
# ptpv2_bus_arbiter

Two-master arbiter and sequencer for the 32-bit on-chip register bus of `ptpv2_core`, running on `bus2ip_clk`. It serialises single-word read/write accesses from a host port (m0) and a servo-engine port (m1) onto one `bus2ip_*` interface, using round-robin priority. A lock qualifier keeps multi-word sequences atomic, such as an RTC seconds/nanoseconds read or a timestamp FIFO pop, and a watchdog prevents a stuck lock from starving the other master.

## Interface
Parameters:
- RD_LAT, 1: cycles from `bus2ip_rd_ce_o` high to `ip2bus_data_i` valid; legal range 1..3.
- LOCK_MAX, 255: maximum idle cycles a locked owner may hold the bus without requesting; legal range 1..65535.

Ports:
- bus2ip_clk  in  1  the single clock.
- bus2ip_rst_n  in  1  reset; synchronous, active-low.
- m0_req_i / m1_req_i  in  1  access request; held until ack.
- m0_wr_i / m1_wr_i  in  1  1 = write, 0 = read; stable while req is high.
- m0_lock_i / m1_lock_i  in  1  keep ownership after this access.
- m0_addr_i / m1_addr_i  in  32  register address.
- m0_wdata_i / m1_wdata_i  in  32  write data.
- m0_ack_o / m1_ack_o  out  1  one-cycle completion pulse.
- m0_rdata_o / m1_rdata_o  out  32  read data; updated only on a read ack, held otherwise.
- bus2ip_addr_o  out  32  address to core.
- bus2ip_data_o  out  32  write data to core.
- bus2ip_rd_ce_o  out  1  read strobe, one cycle.
- bus2ip_wr_ce_o  out  1  write strobe, one cycle.
- ip2bus_data_i  in  32  read data from core.
- grant_o  out  2  one-hot current owner; 00 when idle and unlocked.
- lock_to_o  out  1  one-cycle pulse when the lock watchdog fires.

## Operation
State machine: IDLE, ISSUE, WAIT, ACK.
- **IDLE**
  - Compute the candidate set. If a lock is held, the only candidate is the owner. Otherwise both requesting masters are candidates.
  - With two candidates, the master not served last wins. The round-robin pointer favours m0 after reset.
  - On selection: latch the master id, wr, addr and wdata; drive grant_o; go to ISSUE.
- **ISSUE**
  - Drive `bus2ip_addr_o` and `bus2ip_data_o` from the latches; assert exactly one of rd_ce/wr_ce for this single cycle.
  - Write: go to ACK. Read: go to WAIT.
- **WAIT**
  - Count RD_LAT cycles; the counter starts at 1 in the cycle after ISSUE.
  - When the count equals RD_LAT, capture `ip2bus_data_i` into the owner's rdata register and go to ACK.
- **ACK**
  - Pulse the owner's ack_o.
  - Toggle the round-robin pointer to the other master.
  - Set `lock_held` = owner's lock_i as sampled this cycle.
  - Go to IDLE. Requests are never sampled in ACK.
- **Lock release**
  - In IDLE with lock_held: if the owner's lock_i is low, clear lock_held immediately; the other master is then arbitrated in the same cycle.
  - If the owner's lock_i is high but its req_i is low, increment the idle counter; the counter resets on every grant.
  - When the counter reaches LOCK_MAX: clear lock_held, pulse lock_to_o, and continue normal arbitration from the next cycle.
- **Strobes:** rd_ce and wr_ce are never both high. The strobes are outside ISSUE only when in reset.
- **Address/data when idle:** `bus2ip_addr_o` and `bus2ip_data_o` hold their last values outside ISSUE. They are not required to be zero.
- **Requester contract:** a request with lock_i=1 on a master without the lock is legal and acquires the lock at its ack.

## Timing
- **Write latency:** req sampled in IDLE at cycle T; wr_ce high at T+1; ack at T+2. Minimum 3 cycles per write.
- **Read latency:** rd_ce high at T+1; data sampled at T+1+RD_LAT; ack and rdata at T+2+RD_LAT.
- **Back-to-back:** a requester keeping req high after its ack cycle is a new request, sampled at ack+1.
- **Reset values:** all acks, strobes, grant_o and lock_to_o are 0; addr, data and both rdata are 0x0; lock_held is cleared; the pointer favours m0.
- **Reset mid-operation:** the transaction is aborted, no ack is issued, and any strobe drops in the cycle after reset is sampled low.

## Test plan
- m0 writes 0x0000_1234 to 0x40 with m1 idle → wr_ce at T+1 with addr 0x40 and data 0x1234; m0_ack at T+2; grant_o = 01 during the access.
- m1 reads 0x80 with RD_LAT=2 while the core returns 0xCAFE_0001 → rd_ce at T+1; m1_ack at T+4; m1_rdata = 0xCAFE0001; m0_rdata unchanged.
- Both masters request continuously from reset → grants alternate m0, m1, m0, m1; no strobe overlap.
- m1 locked for three reads while m0 requests throughout → m1 gets three consecutive grants; m0 is granted in the same IDLE cycle in which m1 drops its lock.
- LOCK_MAX=4, m0 holds lock with req low while m1 requests → lock_to_o pulses once after 4 idle cycles; m1 is granted on the next cycle.
- Reset asserted in the WAIT state of a read → no ack; all outputs at reset values; the first post-reset simultaneous request goes to m0.
